// File: rtl/stage5_field_extract_pipe.sv
// stage5_field_extract_pipe: per-lane field extractor with a 2-entry output FIFO
// per lane. A beat is accepted by all lanes together; lanes drain independently.
// Optional hit/miss statistics counters are built when STAGE5_FIELD_STATS_EN is defined.
module stage5_field_extract_pipe #(
    parameter int unsigned NUM_CH                 = 3,
    parameter int unsigned MSG_BITS               = 256,
    parameter int unsigned FIELD_BITS             = 32,
    parameter int unsigned FIELD_LSB              = 64,
    parameter int unsigned MUX_W                  = 4,
    parameter logic [MUX_W-1:0] MUX_SEL           = MUX_W'(4'h1),
    parameter logic [FIELD_BITS-1:0] DEFAULT_VAL  = '0,
    parameter int unsigned CNT_W                  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         message_en,
    output logic                         message_ready,
    input  logic [NUM_CH*MSG_BITS-1:0]   message,
    input  logic [NUM_CH*MUX_W-1:0]      message_mux_control,
    output logic [NUM_CH-1:0]            field_valid,
    input  logic [NUM_CH-1:0]            field_ready,
    output logic [NUM_CH*FIELD_BITS-1:0] field_data,
    output logic [NUM_CH-1:0]            field_hit
`ifdef STAGE5_FIELD_STATS_EN
    ,
    output logic [NUM_CH*CNT_W-1:0]      hit_cnt,
    output logic [NUM_CH*CNT_W-1:0]      miss_cnt
`endif
);

    localparam int unsigned DEPTH = 2;

    // FIFO state per lane
    logic [1:0]            cnt_q    [NUM_CH];
    logic [1:0]            cnt_d    [NUM_CH];
    logic [NUM_CH-1:0]     wr_ptr_q, wr_ptr_d;
    logic [NUM_CH-1:0]     rd_ptr_q, rd_ptr_d;
    logic [FIELD_BITS-1:0] data_q   [NUM_CH][DEPTH];
    logic [FIELD_BITS-1:0] data_d   [NUM_CH][DEPTH];
    logic                  hit_q    [NUM_CH][DEPTH];
    logic                  hit_d    [NUM_CH][DEPTH];

    logic [NUM_CH-1:0]     pop_c;
    logic [NUM_CH-1:0]     can_take_c;
    logic [NUM_CH-1:0]     lane_hit_c;
    logic [FIELD_BITS-1:0] lane_val_c [NUM_CH];
    logic                  push_c;

    // Only the field slice of each lane is consumed; the rest is reduced away here.
    logic unused_message_bits;
    assign unused_message_bits = ^message;

    // Per-lane handshake terms and field selection
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            field_valid[i] = (cnt_q[i] != 2'd0);
            pop_c[i]       = field_valid[i] & field_ready[i];
            can_take_c[i]  = (cnt_q[i] != 2'd2) | pop_c[i];
            lane_hit_c[i]  = (message_mux_control[i*MUX_W +: MUX_W] == MUX_SEL);
            lane_val_c[i]  = lane_hit_c[i] ? message[i*MSG_BITS + FIELD_LSB +: FIELD_BITS]
                                           : DEFAULT_VAL;
        end
    end

    assign message_ready = &can_take_c;
    assign push_c        = message_en & message_ready;

    // Head entry drives the outputs; an empty lane shows the default
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            field_data[i*FIELD_BITS +: FIELD_BITS] = field_valid[i] ? data_q[i][rd_ptr_q[i]]
                                                                   : DEFAULT_VAL;
            field_hit[i] = field_valid[i] & hit_q[i][rd_ptr_q[i]];
        end
    end

    // FIFO next state: push on accept, pop on consumer handshake
    always_comb begin
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        data_d   = data_q;
        hit_d    = hit_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (push_c) begin
                data_d[i][wr_ptr_q[i]] = lane_val_c[i];
                hit_d[i][wr_ptr_q[i]]  = lane_hit_c[i];
                wr_ptr_d[i]            = ~wr_ptr_q[i];
            end
            if (pop_c[i]) begin
                rd_ptr_d[i] = ~rd_ptr_q[i];
            end
            case ({push_c, pop_c[i]})
                2'b10:   cnt_d[i] = cnt_q[i] + 2'd1;
                2'b01:   cnt_d[i] = cnt_q[i] - 2'd1;
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
    end

    // FIFO state register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= 2'd0;
                for (int e = 0; e < DEPTH; e++) begin
                    data_q[i][e] <= DEFAULT_VAL;
                    hit_q[i][e]  <= 1'b0;
                end
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            hit_q    <= hit_d;
        end
    end

`ifdef STAGE5_FIELD_STATS_EN
    logic [CNT_W-1:0] hit_cnt_q  [NUM_CH];
    logic [CNT_W-1:0] hit_cnt_d  [NUM_CH];
    logic [CNT_W-1:0] miss_cnt_q [NUM_CH];
    logic [CNT_W-1:0] miss_cnt_d [NUM_CH];

    // Saturating hit/miss counters, bumped once per accepted beat
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (push_c) begin
                if (lane_hit_c[i]) begin
                    if (hit_cnt_q[i] != {CNT_W{1'b1}}) hit_cnt_d[i] = hit_cnt_q[i] + CNT_W'(1);
                end else begin
                    if (miss_cnt_q[i] != {CNT_W{1'b1}}) miss_cnt_d[i] = miss_cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                hit_cnt_q[i]  <= '0;
                miss_cnt_q[i] <= '0;
            end
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Flatten counters onto the output buses
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            hit_cnt[i*CNT_W +: CNT_W]  = hit_cnt_q[i];
            miss_cnt[i*CNT_W +: CNT_W] = miss_cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_stage5_field_extract_pipe.sv
// Bench for stage5_field_extract_pipe: directed stimulus with a cycle-level
// reference model; expected entries are queued at accept time and popped by the
// checker whenever a lane handshakes. Covers STAGE5_FIELD_STATS_EN when defined.
module tb_stage5_field_extract_pipe;

    localparam int unsigned NCH = 3;
    localparam int unsigned MB  = 256;
    localparam int unsigned FB  = 32;
    localparam int unsigned FL  = 64;
    localparam int unsigned MW  = 4;
    localparam int unsigned CW  = 4;
    localparam int          CMAX = 15;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                message_en = 1'b0;
    logic                message_ready;
    logic [NCH*MB-1:0]   message = '0;
    logic [NCH*MW-1:0]   message_mux_control = '0;
    logic [NCH-1:0]      field_valid;
    logic [NCH-1:0]      field_ready = '1;
    logic [NCH*FB-1:0]   field_data;
    logic [NCH-1:0]      field_hit;
`ifdef STAGE5_FIELD_STATS_EN
    logic [NCH*CW-1:0]   hit_cnt;
    logic [NCH*CW-1:0]   miss_cnt;
`endif

    stage5_field_extract_pipe #(
        .NUM_CH(NCH), .MSG_BITS(MB), .FIELD_BITS(FB), .FIELD_LSB(FL),
        .MUX_W(MW), .MUX_SEL(4'h1), .DEFAULT_VAL(32'h0), .CNT_W(CW)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .message_en          (message_en),
        .message_ready       (message_ready),
        .message             (message),
        .message_mux_control (message_mux_control),
        .field_valid         (field_valid),
        .field_ready         (field_ready),
        .field_data          (field_data),
        .field_hit           (field_hit)
`ifdef STAGE5_FIELD_STATS_EN
        ,
        .hit_cnt             (hit_cnt),
        .miss_cnt            (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [FB:0] sbq [NCH][$];
    int pop_cnt [NCH];
    int m_hit [NCH];
    int m_miss [NCH];

    task automatic chk(input string nm, input int lane, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s lane=%0d got=%h expected=%h t=%0t", nm, lane, act, exp, $time);
        end
    endtask

    function automatic logic [NCH*MB-1:0] mk_msg(input logic [FB-1:0] f0, input logic [FB-1:0] f1,
                                                 input logic [FB-1:0] f2);
        logic [NCH*MB-1:0] m;
        for (int w = 0; w < NCH*MB/32; w++) m[w*32 +: 32] = $urandom;
        m[0*MB + FL +: FB] = f0;
        m[1*MB + FL +: FB] = f1;
        m[2*MB + FL +: FB] = f2;
        return m;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [FB-1:0] f0, input logic [FB-1:0] f1, input logic [FB-1:0] f2,
                         input logic [NCH*MW-1:0] mux);
        message             = mk_msg(f0, f1, f2);
        message_mux_control = mux;
        message_en          = 1'b1;
    endtask

    // Reference model and scoreboard, evaluated mid-cycle
    always @(negedge clk) begin
        logic        rdy_exp;
        logic [NCH-1:0] pop_m;
        logic        h;
        logic [FB:0] e;
        if (!rst_n) begin
            for (int l = 0; l < NCH; l++) begin
                sbq[l].delete();
                m_hit[l]  = 0;
                m_miss[l] = 0;
            end
        end else begin
            rdy_exp = 1'b1;
            for (int l = 0; l < NCH; l++) begin
                chk("valid", l, 64'(field_valid[l]), 64'(sbq[l].size() != 0));
                pop_m[l] = (sbq[l].size() != 0) && field_ready[l];
                if (sbq[l].size() == 2 && !pop_m[l]) rdy_exp = 1'b0;
`ifdef STAGE5_FIELD_STATS_EN
                chk("hit_cnt", l, 64'(hit_cnt[l*CW +: CW]), 64'(m_hit[l]));
                chk("miss_cnt", l, 64'(miss_cnt[l*CW +: CW]), 64'(m_miss[l]));
`endif
            end
            chk("message_ready", 0, 64'(message_ready), 64'(rdy_exp));
            for (int l = 0; l < NCH; l++) begin
                if (pop_m[l]) begin
                    e = sbq[l].pop_front();
                    chk("head", l, 64'({field_hit[l], field_data[l*FB +: FB]}), 64'(e));
                    pop_cnt[l]++;
                end
            end
            if (message_en && rdy_exp) begin
                for (int l = 0; l < NCH; l++) begin
                    h = (message_mux_control[l*MW +: MW] == 4'h1);
                    sbq[l].push_back({h, h ? message[l*MB + FL +: FB] : 32'h0});
                    if (h) begin
                        if (m_hit[l] < CMAX) m_hit[l]++;
                    end else begin
                        if (m_miss[l] < CMAX) m_miss[l]++;
                    end
                end
            end
        end
    end

    initial begin
        int base1;
        int base [NCH];
        logic [NCH*MW-1:0] mux;
        for (int l = 0; l < NCH; l++) pop_cnt[l] = 0;

        // Reset state
        step(); step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_valid", 0, 64'(field_valid), 64'(0));
        chk("rst_data", 0, 64'(field_data), 64'(0));
        chk("rst_hit", 0, 64'(field_hit), 64'(0));

        // Basic extract: lane 0 hit, lanes 1/2 default
        step();
        drive(32'hDEADBEEF, 32'h11111111, 32'h22222222, 12'h221);
        step();
        message_en = 1'b0;
        @(negedge clk);
        chk("basic_valid", 0, 64'(field_valid), 64'(3'b111));
        chk("basic_data", 0, 64'(field_data[0 +: FB]), 64'(32'hDEADBEEF));
        chk("basic_hit", 0, 64'(field_hit[0]), 64'(1));
        chk("basic_data", 1, 64'(field_data[FB +: FB]), 64'(0));
        chk("basic_hit", 1, 64'(field_hit[1]), 64'(0));
        chk("basic_data", 2, 64'(field_data[2*FB +: FB]), 64'(0));
        chk("basic_hit", 2, 64'(field_hit[2]), 64'(0));
        step(); step();

        // Backpressure on lane 1
        base1 = pop_cnt[1];
        field_ready = 3'b101;
        drive(32'hA0000001, 32'hB0000001, 32'hC0000001, 12'h111);
        step();
        drive(32'hA0000002, 32'hB0000002, 32'hC0000002, 12'h111);
        step();
        drive(32'hA0000003, 32'hB0000003, 32'hC0000003, 12'h111);
        @(negedge clk);
        chk("bp_ready_low", 1, 64'(message_ready), 64'(0));
        step();
        field_ready = 3'b111;
        @(negedge clk);
        chk("bp_ready_rise", 1, 64'(message_ready), 64'(1));
        step();
        message_en = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("bp_lane1_pops", 1, 64'(pop_cnt[1] - base1), 64'(3));

        // Full throughput: 100 beats back to back
        for (int l = 0; l < NCH; l++) base[l] = pop_cnt[l];
        for (int k = 0; k < 100; k++) begin
            for (int l = 0; l < NCH; l++)
                mux[l*MW +: MW] = (((k + l) % 3) == 0) ? 4'h1 : 4'((k % 7) + 2);
            drive(32'h10000000 + 32'(k), 32'h20000000 + 32'(k), 32'h30000000 + 32'(k), mux);
            step();
        end
        message_en = 1'b0;
        step(); step(); step();
        for (int l = 0; l < NCH; l++) chk("tput_pops", l, 64'(pop_cnt[l] - base[l]), 64'(100));

        // Idle: no enqueue without message_en
        for (int k = 0; k < 10; k++) begin
            message             = mk_msg($urandom, $urandom, $urandom);
            message_mux_control = 12'h111;
            step();
        end
        @(negedge clk);
        chk("idle_valid", 0, 64'(field_valid), 64'(0));
        step();

        // Reset mid-operation with lane 2 full
        field_ready = 3'b011;
        drive(32'h0000AAA1, 32'h0000BBB1, 32'h0000CCC1, 12'h111);
        step();
        drive(32'h0000AAA2, 32'h0000BBB2, 32'h0000CCC2, 12'h121);
        step();
        drive(32'h0000AAA3, 32'h0000BBB3, 32'h0000CCC3, 12'h111);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        message_en = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 0, 64'(field_valid), 64'(0));
        chk("mid_rst_data", 0, 64'(field_data), 64'(0));
`ifdef STAGE5_FIELD_STATS_EN
        chk("mid_rst_cnt", 0, 64'({hit_cnt, miss_cnt}), 64'(0));
`endif
        step();
        field_ready = 3'b111;

        // Stats: 20 hits on lane 0, counters saturate
        for (int k = 0; k < 20; k++) begin
            drive(32'h5000_0000 + 32'(k), 32'h6000_0000, 32'h7000_0000, 12'h221);
            step();
        end
        message_en = 1'b0;
        step(); step(); step();
`ifdef STAGE5_FIELD_STATS_EN
        @(negedge clk);
        chk("stats_hit_sat", 0, 64'(hit_cnt[0 +: CW]), 64'(15));
        chk("stats_miss_zero", 0, 64'(miss_cnt[0 +: CW]), 64'(0));
        chk("stats_miss_sat", 1, 64'(miss_cnt[CW +: CW]), 64'(15));
        step();
`endif
        for (int l = 0; l < NCH; l++) chk("drained", l, 64'(sbq[l].size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute run-time bound
    initial begin
        #200000;
        $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/stage5_field_extract_pipe.md
# stage5_field_extract_pipe

Parametrised, registered successor to the stage-5 single-field extractors. Each accepted message beat carries `NUM_CH` message lanes. For each lane, the block pulls one field out of the message, or substitutes a default value when that lane's mux control does not select the field's message type. Results are buffered in a 2-entry per-lane output FIFO with an independent valid/ready handshake. The block sits between the stage-4 message router and the stage-6 order-book update logic.

## Interface
Parameters:
- `NUM_CH`, 3: number of message lanes.
- `MSG_BITS`, 256: width of one message lane.
- `FIELD_BITS`, 32: width of the extracted field.
- `FIELD_LSB`, 64: LSB position of the field; the field is `msg[FIELD_LSB+FIELD_BITS-1 : FIELD_LSB]`.
- `MUX_W`, 4: width of a lane's mux control.
- `MUX_SEL`, 4'h1: mux control value that selects the field's message type.
- `DEFAULT_VAL`, 0: value substituted when the lane is not selected.
- `CNT_W`, 16: statistics counter width.

Ports:
- `clk` input 1: clock.
- `rst_n` input 1: reset; synchronous, active-low.
- `message_en` input 1: input beat valid.
- `message_ready` output 1: input beat accepted this cycle when `message_en` is also high.
- `message` input `NUM_CH*MSG_BITS`: lane i occupies bits `[i*MSG_BITS +: MSG_BITS]`.
- `message_mux_control` input `NUM_CH*MUX_W`: lane i occupies bits `[i*MUX_W +: MUX_W]`.
- `field_valid` output `NUM_CH`: per-lane output valid.
- `field_ready` input `NUM_CH`: per-lane consumer ready.
- `field_data` output `NUM_CH*FIELD_BITS`: per-lane field value or `DEFAULT_VAL`.
- `field_hit` output `NUM_CH`: 1 means the field was extracted; 0 means the default was substituted.
- `hit_cnt` output `NUM_CH*CNT_W`: per-lane extracted count; present only with the statistics macro.
- `miss_cnt` output `NUM_CH*CNT_W`: per-lane defaulted count; present only with the statistics macro.

## Operation
- Input accept: a beat is accepted when `message_en && message_ready`.
- `message_ready` is combinational: it is 1 only when every lane FIFO has fewer than 2 entries, or when every lane that is full is popping this cycle.
  - A beat is always accepted by all lanes together; lanes never partially accept.
- Per lane, on accept:
  - `hit = (mux_i == MUX_SEL)`.
  - Entry pushed = {`hit`, `hit ? field : DEFAULT_VAL`}.
- Lane FIFO:
  - 2 entries, with a 2-bit count of 0..2, a write pointer and a read pointer that each wrap modulo 2.
  - `field_valid[i] = (count_i != 0)`.
  - `field_data` and `field_hit` always present the head entry.
- Pop occurs when `field_valid[i] && field_ready[i]`.
- Count update per lane:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop together: count unchanged, and both pointers advance.
- Lanes drain independently; a stalled lane blocks new input beats only once it is full.
- `message_en = 0`: nothing is enqueued. No default entries are generated.
- Reset:
  - All FIFO counts and pointers are cleared.
  - `field_valid = 0`, `field_data = DEFAULT_VAL`, `field_hit = 0`.
  - Counters are cleared.
  - In-flight entries are discarded; no output appears before a new accept.

## Timing
- Latency: an accept in cycle N into an empty lane gives `field_valid` high in cycle N+1.
- Throughput: 1 beat per cycle while all `field_ready` are held high.
- `message_ready` has a combinational path from `field_ready`. The FIFO state itself is registered; data passes through no combinational path from input to output.
- With a lane full and its `field_ready` low, `message_ready` is 0. It rises in the same cycle that `field_ready` rises.
- Output data is stable while `field_valid && !field_ready`.
- Reset is sampled at the `clk` edge. When `rst_n` is low at an edge, all outputs take their reset values after that edge, regardless of `message_en` or `field_ready`.

## Configuration
- Macro: `STAGE5_FIELD_STATS_EN`.
- When defined:
  - Each lane has `hit_cnt` and `miss_cnt` counters.
  - On each accept, `hit_cnt` increments when `hit = 1` and `miss_cnt` increments when `hit = 0`.
  - Counters saturate at `2^CNT_W-1`.
  - Counters reset to 0.
- When undefined:
  - The `hit_cnt` and `miss_cnt` ports and their counters are not built.
  - All other behaviour is identical.

## Test plan
- Basic extract: reset, then accept one beat. Lane 0 mux=`MUX_SEL` with field=32'hDEADBEEF; lanes 1 and 2 mux=4'h2. Next cycle: `field_valid` = 3'b111. Lane 0 shows data 32'hDEADBEEF with hit=1; lanes 1 and 2 show data 0 with hit=0.
- Backpressure: hold `field_ready[1] = 0` and present 3 consecutive beats. Beats 1 and 2 are accepted and `message_ready` drops for beat 3. Raise `field_ready[1]`: beat 3 is accepted in that same cycle, and lane 1 outputs all three beats in order.
- Full throughput: keep `message_en = 1` and `field_ready = 3'b111` for 100 beats. Expect 100 outputs per lane with no bubbles after the first cycle, and data in order.
- Idle: `message_en = 0` for 10 cycles with random message data. `field_valid` stays 0 throughout.
- Reset mid-operation: fill lane 2 with 2 entries, then pull `rst_n` low for 1 cycle. After that edge, `field_valid = 0` and `field_data = DEFAULT_VAL`; with the macro defined, counters read 0.
- Stats (macro defined, `CNT_W = 4`): accept 20 beats, all hits on lane 0. `hit_cnt[0]` saturates at 15 and `miss_cnt[0]` stays 0.
